// File: rtl/sram_1rw_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port 1rw OpenRAM macro.
// Optional zero-fill of the whole array after reset when SRAM_ARB_INIT_EN is defined.
module sram_1rw_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 88,
    parameter int MASK_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_wen,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [MASK_W-1:0] a_req_wmask,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_resp_valid,
    input  logic              a_resp_ready,
    output logic [DATA_W-1:0] a_resp_rdata,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_wen,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [MASK_W-1:0] b_req_wmask,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_resp_valid,
    input  logic              b_resp_ready,
    output logic [DATA_W-1:0] b_resp_rdata,
    output logic              mem_csb0,
    output logic              mem_web0,
    output logic [ADDR_W-1:0] mem_addr0,
    output logic [MASK_W-1:0] mem_wmask0,
    output logic [DATA_W-1:0] mem_din0,
    input  logic [DATA_W-1:0] mem_dout0,
    output logic              init_done
);

    logic              in_init;
    logic [ADDR_W-1:0] init_addr;

`ifdef SRAM_ARB_INIT_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t state, state_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT)
                init_addr <= init_addr + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_INIT && init_addr == LAST_ADDR)
            state_next = ST_RUN;
    end

    assign in_init   = (state == ST_INIT);
    assign init_done = (state == ST_RUN);
`else
    assign in_init   = 1'b0;
    assign init_addr = '0;
    assign init_done = 1'b1;
`endif

    logic              rr_ptr;
    logic              rd_pending;
    logic              rd_owner;
    logic              a_elig, b_elig;
    logic              grant_a, grant_b, grant;
    logic              sel_wen;
    logic [ADDR_W-1:0] sel_addr;
    logic [MASK_W-1:0] sel_wmask;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W-1:0] addr_q;
    logic [MASK_W-1:0] wmask_q;
    logic [DATA_W-1:0] din_q;
    logic              run;
    logic              capture_a, capture_b;

    // Gating with reset_n keeps the macro deselected while reset is held.
    assign run = reset_n && !in_init;

    // A read needs a free response slot: nothing in flight and the buffer empty or draining.
    assign a_elig = a_req_valid && (a_req_wen ||
                    (!(rd_pending && !rd_owner) && (!a_resp_valid || a_resp_ready)));
    assign b_elig = b_req_valid && (b_req_wen ||
                    (!(rd_pending && rd_owner) && (!b_resp_valid || b_resp_ready)));

    assign grant_a = run && a_elig && (!b_elig || !rr_ptr);
    assign grant_b = run && b_elig && (!a_elig || rr_ptr);
    assign grant   = grant_a || grant_b;

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;

    assign sel_wen   = grant_b ? b_req_wen   : a_req_wen;
    assign sel_addr  = grant_b ? b_req_addr  : a_req_addr;
    assign sel_wmask = grant_b ? b_req_wmask : a_req_wmask;
    assign sel_wdata = grant_b ? b_req_wdata : a_req_wdata;

    // Idle cycles replay the last address/data so the macro pins stay quiet.
    always_comb begin
        mem_csb0   = 1'b1;
        mem_web0   = 1'b1;
        mem_addr0  = addr_q;
        mem_wmask0 = wmask_q;
        mem_din0   = din_q;
        if (reset_n && in_init) begin
            mem_csb0   = 1'b0;
            mem_web0   = 1'b0;
            mem_addr0  = init_addr;
            mem_wmask0 = '1;
            mem_din0   = '0;
        end else if (grant) begin
            mem_csb0   = 1'b0;
            mem_web0   = !sel_wen;
            mem_addr0  = sel_addr;
            mem_wmask0 = sel_wen ? sel_wmask : '0;
            mem_din0   = sel_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wmask_q <= '0;
            din_q   <= '0;
        end else if (!mem_csb0) begin
            addr_q  <= mem_addr0;
            wmask_q <= mem_wmask0;
            din_q   <= mem_din0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= 1'b0;
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            rd_pending <= grant && !sel_wen;
            rd_owner   <= grant_b;
            if (grant_a)
                rr_ptr <= 1'b1;
            else if (grant_b)
                rr_ptr <= 1'b0;
        end
    end

    assign capture_a = rd_pending && !rd_owner;
    assign capture_b = rd_pending && rd_owner;

    // A fresh capture wins over a pop in the same cycle, so valid stays set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_resp_valid <= 1'b0;
            a_resp_rdata <= '0;
            b_resp_valid <= 1'b0;
            b_resp_rdata <= '0;
        end else begin
            if (capture_a) begin
                a_resp_valid <= 1'b1;
                a_resp_rdata <= mem_dout0;
            end else if (a_resp_valid && a_resp_ready) begin
                a_resp_valid <= 1'b0;
            end
            if (capture_b) begin
                b_resp_valid <= 1'b1;
                b_resp_rdata <= mem_dout0;
            end else if (b_resp_valid && b_resp_ready) begin
                b_resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_1rw_port_arbiter.sv
// Directed bench for sram_1rw_port_arbiter with a behavioural 1rw macro model.
// Honours SRAM_ARB_INIT_EN for the zero-fill phase.
module tb_sram_1rw_port_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 88;
    localparam int MASK_W = 4;
    localparam int GW     = DATA_W / MASK_W;

    logic              clock;
    logic              reset_n;
    logic              a_req_valid, a_req_ready, a_req_wen;
    logic [ADDR_W-1:0] a_req_addr;
    logic [MASK_W-1:0] a_req_wmask;
    logic [DATA_W-1:0] a_req_wdata;
    logic              a_resp_valid, a_resp_ready;
    logic [DATA_W-1:0] a_resp_rdata;
    logic              b_req_valid, b_req_ready, b_req_wen;
    logic [ADDR_W-1:0] b_req_addr;
    logic [MASK_W-1:0] b_req_wmask;
    logic [DATA_W-1:0] b_req_wdata;
    logic              b_resp_valid, b_resp_ready;
    logic [DATA_W-1:0] b_resp_rdata;
    logic              mem_csb0, mem_web0;
    logic [ADDR_W-1:0] mem_addr0;
    logic [MASK_W-1:0] mem_wmask0;
    logic [DATA_W-1:0] mem_din0;
    logic [DATA_W-1:0] mem_dout0;
    logic              init_done;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mem_array [1<<ADDR_W];

    localparam logic [DATA_W-1:0] D1 = 88'h00FF_1122_3344_5566_7788_AB;
    localparam logic [DATA_W-1:0] D3 = 88'h0A0B_0C0D_0E0F_1011_1213_14;
    localparam logic [DATA_W-1:0] MASKED_EXP = {{(DATA_W-GW){1'b1}}, {GW{1'b0}}};

`ifdef SRAM_ARB_INIT_EN
    localparam logic INIT_RESET_VAL = 1'b0;
`else
    localparam logic INIT_RESET_VAL = 1'b1;
`endif

    sram_1rw_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_wen(a_req_wen),
        .a_req_addr(a_req_addr), .a_req_wmask(a_req_wmask), .a_req_wdata(a_req_wdata),
        .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready), .a_resp_rdata(a_resp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_wen(b_req_wen),
        .b_req_addr(b_req_addr), .b_req_wmask(b_req_wmask), .b_req_wdata(b_req_wdata),
        .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready), .b_resp_rdata(b_resp_rdata),
        .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_addr0(mem_addr0),
        .mem_wmask0(mem_wmask0), .mem_din0(mem_din0), .mem_dout0(mem_dout0),
        .init_done(init_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Macro model: masked write at the select edge, read data one cycle later.
    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) mem_array[i] = '1;
        mem_dout0 = '0;
    end

    always @(posedge clock) begin
        if (!mem_csb0) begin
            if (!mem_web0) begin
                for (int g = 0; g < MASK_W; g++)
                    if (mem_wmask0[g]) mem_array[mem_addr0][g*GW +: GW] <= mem_din0[g*GW +: GW];
            end else begin
                mem_dout0 <= mem_array[mem_addr0];
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Walks the zero-fill phase (if compiled in) until init_done, bounded.
    task automatic wait_init();
`ifdef SRAM_ARB_INIT_EN
        for (int i = 0; i < 80 && !init_done; i++) step();
`endif
        check("init_done_after_reset", init_done, 1'b1);
    endtask

    initial begin
        reset_n      = 1'b0;
        a_req_valid  = 1'b1; a_req_wen = 1'b1; a_req_addr = 6'd7; a_req_wmask = 4'hF; a_req_wdata = '0;
        b_req_valid  = 1'b0; b_req_wen = 1'b0; b_req_addr = '0;   b_req_wmask = '0;   b_req_wdata = '0;
        a_resp_ready = 1'b0; b_resp_ready = 1'b0;

        #2;
        check("rst_csb",       mem_csb0, 1'b1);
        check("rst_web",       mem_web0, 1'b1);
        check("rst_addr",      mem_addr0, 6'd0);
        check("rst_wmask",     mem_wmask0, 4'd0);
        check("rst_din",       mem_din0, 88'd0);
        check("rst_a_ready",   a_req_ready, 1'b0);
        check("rst_a_valid",   a_resp_valid, 1'b0);
        check("rst_b_valid",   b_resp_valid, 1'b0);
        check("rst_a_rdata",   a_resp_rdata, 88'd0);
        check("rst_b_rdata",   b_resp_rdata, 88'd0);
        check("rst_init_done", init_done, INIT_RESET_VAL);

        #10;
        reset_n     = 1'b1;
        a_req_valid = 1'b0;

`ifdef SRAM_ARB_INIT_EN
        // Zero-fill: a pending read of addr 63 must wait for the whole sweep.
        for (int i = 0; i < 64; i++) begin
            a_req_valid = 1'b1; a_req_wen = 1'b0; a_req_addr = 6'd63;
            #1;
            check("init_ready", a_req_ready, 1'b0);
            check("init_addr",  mem_addr0, i[5:0]);
            check("init_csb",   mem_csb0 | mem_web0, 1'b0);
            step();
        end
        check("init_done_rise", init_done, 1'b1);
        check("init_rd_grant",  a_req_ready, 1'b1);
        step();
        a_req_valid = 1'b0;
        step();
        check("init_rd_valid", a_resp_valid, 1'b1);
        check("init_rd_data",  a_resp_rdata, 88'd0);
        a_resp_ready = 1'b1;
        step();
        a_resp_ready = 1'b0;
`endif

        // Single write then read of addr 5 by A.
        a_req_valid = 1'b1; a_req_wen = 1'b1; a_req_addr = 6'd5; a_req_wmask = 4'hF; a_req_wdata = D1;
        #1;
        check("wr_a_ready", a_req_ready, 1'b1);
        check("wr_b_ready", b_req_ready, 1'b0);
        check("wr_csb",     mem_csb0, 1'b0);
        check("wr_web",     mem_web0, 1'b0);
        check("wr_addr",    mem_addr0, 6'd5);
        check("wr_din",     mem_din0, D1);
        step();
        a_req_wen = 1'b0;
        #1;
        check("rd_ready", a_req_ready, 1'b1);
        check("rd_web",   mem_web0, 1'b1);
        check("rd_wmask", mem_wmask0, 4'd0);
        step();
        a_req_valid = 1'b0;
        #1;
        check("rd_t1_valid", a_resp_valid, 1'b0);
        check("idle_csb",    mem_csb0, 1'b1);
        check("idle_addr",   mem_addr0, 6'd5);
        step();
        check("rd_t2_valid", a_resp_valid, 1'b1);
        check("rd_t2_data",  a_resp_rdata, D1);
        check("rd_b_valid",  b_resp_valid, 1'b0);
        a_resp_ready = 1'b1;
        step();
        a_resp_ready = 1'b0;
        check("rd_popped", a_resp_valid, 1'b0);

        // Contention: both write every cycle; last grant was A so B leads.
        a_req_valid = 1'b1; a_req_wen = 1'b1; a_req_addr = 6'd10; a_req_wdata = 88'h1;
        b_req_valid = 1'b1; b_req_wen = 1'b1; b_req_addr = 6'd20; b_req_wmask = 4'hF; b_req_wdata = 88'h2;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_a_ready", a_req_ready, (i % 2) == 1);
            check("rr_b_ready", b_req_ready, (i % 2) == 0);
            check("rr_csb",     mem_csb0, 1'b0);
            step();
        end
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;

        // Masked write: only the low group is cleared.
        a_req_valid = 1'b1; a_req_wen = 1'b1; a_req_addr = 6'd9; a_req_wmask = 4'hF; a_req_wdata = '1;
        step();
        a_req_wmask = 4'b0001; a_req_wdata = '0;
        #1;
        check("mw_wmask", mem_wmask0, 4'b0001);
        step();
        a_req_wen = 1'b0;
        step();
        a_req_valid = 1'b0;
        step();
        check("mw_valid", a_resp_valid, 1'b1);
        check("mw_data",  a_resp_rdata, MASKED_EXP);
        a_resp_ready = 1'b1;
        step();
        a_resp_ready = 1'b0;

        // Backpressure on B while A keeps writing.
        b_req_valid = 1'b1; b_req_wen = 1'b1; b_req_addr = 6'd3; b_req_wmask = 4'hF; b_req_wdata = D3;
        step();
        b_req_wen = 1'b0;
        #1;
        check("bp_first_grant", b_req_ready, 1'b1);
        step();
        a_req_valid = 1'b1; a_req_wen = 1'b1; a_req_addr = 6'd30; a_req_wmask = 4'hF; a_req_wdata = 88'h55;
        #1;
        check("bp_inflight_block", b_req_ready, 1'b0);
        check("bp_a_proceeds",     a_req_ready, 1'b1);
        check("bp_t1_valid",       b_resp_valid, 1'b0);
        step();
        for (int k = 0; k < 5; k++) begin
            a_req_addr = 6'd31 + k[5:0];
            #1;
            check("bp_hold_valid", b_resp_valid, 1'b1);
            check("bp_hold_data",  b_resp_rdata, D3);
            check("bp_b_blocked",  b_req_ready, 1'b0);
            check("bp_a_granted",  a_req_ready, 1'b1);
            step();
        end
        a_req_valid  = 1'b0;
        b_resp_ready = 1'b1;
        #1;
        check("bp_second_grant", b_req_ready, 1'b1);
        check("bp_second_web",   mem_web0, 1'b1);
        step();
        b_req_valid  = 1'b0;
        b_resp_ready = 1'b0;
        #1;
        check("bp_popped", b_resp_valid, 1'b0);
        step();
        check("bp_second_valid", b_resp_valid, 1'b1);
        check("bp_second_data",  b_resp_rdata, D3);
        b_resp_ready = 1'b1;
        step();
        b_resp_ready = 1'b0;

        // Reset while A's read is in flight and B's response is buffered.
        b_req_valid = 1'b1; b_req_wen = 1'b0; b_req_addr = 6'd3;
        #1;
        check("mr_b_grant", b_req_ready, 1'b1);
        step();
        b_req_valid = 1'b0;
        a_req_valid = 1'b1; a_req_wen = 1'b0; a_req_addr = 6'd5;
        #1;
        check("mr_a_grant", a_req_ready, 1'b1);
        step();
        check("mr_b_buffered", b_resp_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mr_b_valid", b_resp_valid, 1'b0);
        check("mr_b_rdata", b_resp_rdata, 88'd0);
        check("mr_a_valid", a_resp_valid, 1'b0);
        check("mr_csb",     mem_csb0, 1'b1);
        step();
        a_req_valid = 1'b0;
        #1;
        check("mr_no_capture", a_resp_valid, 1'b0);
        reset_n = 1'b1;
        wait_init();
        step();
        step();
        check("mr_a_stale", a_resp_valid, 1'b0);
        check("mr_b_stale", b_resp_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
